// File: rtl/pc_target_table_if.sv
// Lookup and write bus of the programmable branch-target table.
// Master drives requests; slave returns the registered target result.
interface pc_target_table_if #(
  parameter int D     = 10,
  parameter int DEPTH = 16
);
  localparam int A = $clog2(DEPTH);

  logic         lk_valid;
  logic [A-1:0] lk_addr;
  logic [D-1:0] pc;
  logic         tgt_valid;
  logic [D-1:0] target;
  logic         miss;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [D-1:0] wr_data;
  logic         wr_rel;

  modport master (
    output lk_valid, lk_addr, pc,
    output wr_en, wr_addr, wr_data, wr_rel,
    input  tgt_valid, target, miss
  );

  modport slave (
    input  lk_valid, lk_addr, pc,
    input  wr_en, wr_addr, wr_data, wr_rel,
    output tgt_valid, target, miss
  );
endinterface

// File: rtl/pc_target_table.sv
// Programmable branch-target table: absolute or PC-relative entries.
// Optional hit/miss counters enabled by PC_TARGET_HITCNT_EN.
module pc_target_table #(
  parameter int D     = 10,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  output logic busy,
  pc_target_table_if.slave bus
`ifdef PC_TARGET_HITCNT_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int A = $clog2(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t           r_state;
  logic [A-1:0]     r_cnt;
  logic [D-1:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_rel;
  logic [DEPTH-1:0] r_ok;
  logic             r_busy;
  logic             r_tv;
  logic [D-1:0]     r_tgt;
  logic             r_miss;

  logic         w_lk;
  logic         w_wr;
  logic         w_coll;
  logic         w_ok;
  logic         w_rel;
  logic [D-1:0] w_data;
  logic [D-1:0] w_res;

  assign w_lk   = (r_state == RUN) && bus.lk_valid;
  assign w_wr   = (r_state == RUN) && bus.wr_en;
  assign w_coll = w_wr && (bus.wr_addr == bus.lk_addr);

  // Same-edge write to the looked-up entry is forwarded.
  always_comb begin
    w_ok   = r_ok[bus.lk_addr];
    w_rel  = r_rel[bus.lk_addr];
    w_data = r_data[bus.lk_addr];
    if (w_coll) begin
      w_ok   = 1'b1;
      w_rel  = bus.wr_rel;
      w_data = bus.wr_data;
    end
  end

  always_comb begin
    w_res = '0;
    unique case (1'b1)
      !w_ok:          w_res = bus.pc + D'(1);
      w_ok && w_rel:  w_res = bus.pc + w_data;
      w_ok && !w_rel: w_res = w_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_tv    <= 1'b0;
      r_tgt   <= '0;
      r_miss  <= 1'b0;
    end else begin
      r_tv <= 1'b0;
      unique case (r_state)
        INIT: begin
          r_data[r_cnt] <= '0;
          r_rel[r_cnt]  <= 1'b0;
          r_ok[r_cnt]   <= 1'b0;
          r_cnt         <= r_cnt + A'(1);
          if (r_cnt == A'(DEPTH - 1)) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          if (w_wr) begin
            r_data[bus.wr_addr] <= bus.wr_data;
            r_rel[bus.wr_addr]  <= bus.wr_rel;
            r_ok[bus.wr_addr]   <= 1'b1;
          end
          if (w_lk) begin
            r_tv   <= 1'b1;
            r_tgt  <= w_res;
            r_miss <= !w_ok;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign busy          = r_busy;
  assign bus.tgt_valid = r_tv;
  assign bus.target    = r_tgt;
  assign bus.miss      = r_miss;

`ifdef PC_TARGET_HITCNT_EN
  logic [15:0] r_hits;
  logic [15:0] r_misses;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (w_lk) begin
      if (w_ok && r_hits != 16'hFFFF)
        r_hits <= r_hits + 16'd1;
      if (!w_ok && r_misses != 16'hFFFF)
        r_misses <= r_misses + 16'd1;
    end
  end

  assign hit_count  = r_hits;
  assign miss_count = r_misses;
`endif
endmodule

// File: tb/tb_pc_target_table.sv
// Randomized bench for pc_target_table against a table-level model.
// Optional counters checked when PC_TARGET_HITCNT_EN is defined.
module tb_pc_target_table;
  localparam int D     = 10;
  localparam int DEPTH = 16;
  localparam int A     = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  always #5 clk = ~clk;

  pc_target_table_if #(.D(D), .DEPTH(DEPTH)) bus ();

`ifdef PC_TARGET_HITCNT_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  pc_target_table #(.D(D), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .busy  (busy),
    .bus   (bus.slave)
`ifdef PC_TARGET_HITCNT_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  logic [D-1:0] m_data [DEPTH];
  bit           m_rel  [DEPTH];
  bit           m_ok   [DEPTH];
  int           m_init = DEPTH;
  bit           m_tv;
  logic [D-1:0] m_tgt;
  bit           m_miss;
  int           m_hits;
  int           m_misses;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit lk,
                     input logic [A-1:0] la, input logic [D-1:0] p,
                     input bit we, input logic [A-1:0] wa,
                     input logic [D-1:0] wd, input bit wr);
    reset        = rst;
    bus.lk_valid = lk;
    bus.lk_addr  = la;
    bus.pc       = p;
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.wr_rel   = wr;
    @(posedge clk);
    if (rst) begin
      m_init   = DEPTH;
      m_tv     = 0;
      m_tgt    = '0;
      m_miss   = 0;
      m_hits   = 0;
      m_misses = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_data[i] = '0;
        m_rel[i]  = 0;
        m_ok[i]   = 0;
      end
    end else if (m_init > 0) begin
      m_init--;
      m_tv = 0;
    end else begin
      if (we) begin
        m_data[wa] = wd;
        m_rel[wa]  = wr;
        m_ok[wa]   = 1;
      end
      m_tv = lk;
      if (lk) begin
        if (!m_ok[la]) begin
          m_tgt  = p + D'(1);
          m_miss = 1;
          if (m_misses < 65535) m_misses++;
        end else begin
          m_tgt  = m_rel[la] ? p + m_data[la] : m_data[la];
          m_miss = 0;
          if (m_hits < 65535) m_hits++;
        end
      end
    end
    #1;
    chk("busy", 32'(busy), 32'(m_init > 0));
    chk("tgt_valid", 32'(bus.tgt_valid), 32'(m_tv));
    chk("target", 32'(bus.target), 32'(m_tgt));
    chk("miss", 32'(bus.miss), 32'(m_miss));
`ifdef PC_TARGET_HITCNT_EN
    chk("hit_count", 32'(hit_count), 32'(m_hits));
    chk("miss_count", 32'(miss_count), 32'(m_misses));
`endif
  endtask

  task automatic idle();
    cyc(0, 0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic wr(input logic [A-1:0] a, input logic [D-1:0] d,
                    input bit r);
    cyc(0, 0, '0, '0, 1, a, d, r);
  endtask

  task automatic lk(input logic [A-1:0] a, input logic [D-1:0] p);
    cyc(0, 1, a, p, 0, '0, '0, 0);
  endtask

  initial begin
    cyc(1, 0, '0, '0, 0, '0, '0, 0);
    chk("rst_busy", 32'(busy), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 3) lk(4'd0, 10'd7);
      else idle();
    end
    chk("sweep_done", 32'(busy), 32'd0);

    wr(4'd1, 10'd9, 0);
    lk(4'd1, 10'd0);
    chk("abs_hit", 32'(bus.target), 32'd9);
    wr(4'd2, 10'h3FB, 1);
    lk(4'd2, 10'd4);
    chk("rel_neg", 32'(bus.target), 32'h3FF);
    wr(4'd3, 10'd20, 1);
    lk(4'd3, 10'd1020);
    chk("rel_wrap", 32'(bus.target), 32'd16);
    lk(4'd7, 10'd1023);
    chk("miss_wrap", 32'(bus.target), 32'd0);
    lk(4'd1, 10'd0);
    lk(4'd7, 10'd1023);
    chk("b2b_miss", 32'(bus.miss), 32'd1);
    cyc(0, 1, 4'd5, 10'd0, 1, 4'd5, 10'd100, 0);
    chk("bypass", 32'(bus.target), 32'd100);
    idle();
    chk("hold", 32'(bus.target), 32'd100);

    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 99) == 0),
          1'($urandom), A'($urandom), D'($urandom),
          1'($urandom), A'($urandom), D'($urandom), 1'($urandom));
    end

    cyc(1, 0, '0, '0, 0, '0, '0, 0);
    for (int i = 0; i < DEPTH; i++) idle();
`ifdef PC_TARGET_HITCNT_EN
    chk("cnt_clear", 32'({hit_count, miss_count}), 32'd0);
`endif
    lk(4'd1, 10'd50);
    chk("post_rst", 32'(bus.target), 32'd51);
    chk("post_miss", 32'(bus.miss), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
